// File: rtl/rew_path_cmd_gen.sv
// REW path command generator: turns the current REW phase into a burst of
// per-chunk DRAM commands and returns one Transfer pulse per accepted command.
// Optional sticky protocol checker enabled by defining REW_CMD_CHECK_EN.
module rew_path_cmd_gen #(
   parameter int ADDR_WIDTH  = 32,
   parameter int LEAF_WIDTH  = 16,
   parameter int PATH_STRIDE = 4096,
   parameter int BURST_BYTES = 64,
   parameter int RW_R_Chunk  = 8,
   parameter int RW_W_Chunk  = 8,
   parameter int RO_R_Chunk  = 4,
   parameter int RO_W_Chunk  = 0
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  RWAccess,
   input  logic                  ROAccess,
   input  logic                  Read,
   input  logic                  Writeback,
   input  logic [LEAF_WIDTH-1:0] LeafIn,
   input  logic                  LeafInValid,
   output logic                  LeafInReady,
   output logic [ADDR_WIDTH-1:0] CmdAddr,
   output logic                  CmdWrite,
   output logic                  CmdValid,
   input  logic                  CmdReady,
   output logic                  RW_R_Transfer,
   output logic                  RW_W_Transfer,
   output logic                  RO_R_Transfer,
   output logic                  RO_W_Transfer,
   output logic                  Busy
`ifdef REW_CMD_CHECK_EN
   ,
   output logic                  ProtocolErr
`endif
);

   localparam int MAX_RW    = (RW_R_Chunk > RW_W_Chunk) ? RW_R_Chunk : RW_W_Chunk;
   localparam int MAX_RO    = (RO_R_Chunk > RO_W_Chunk) ? RO_R_Chunk : RO_W_Chunk;
   localparam int MAX_CHUNK = (MAX_RW > MAX_RO) ? MAX_RW : MAX_RO;
   localparam int CW        = (MAX_CHUNK > 1) ? $clog2(MAX_CHUNK) : 1;

   typedef enum logic [1:0] {ST_Idle, ST_Leaf, ST_Issue, ST_Wait} state_t;

   state_t                state, state_nxt;
   logic [1:0]            phase_now, phase_reg;
   logic                  phase_vld;
   logic [LEAF_WIDTH-1:0] leaf_reg;
   logic [CW-1:0]         chunk_ctr, chunk_last;
   logic                  wb_empty;
   logic                  cmd_hs;

   assign phase_now = {ROAccess, Writeback};
   assign phase_vld = (RWAccess | ROAccess) & (Read | Writeback);
   assign cmd_hs    = (state == ST_Issue) & CmdReady;

   // A writeback phase configured with zero chunks skips straight to ST_Wait.
   always_comb begin
      wb_empty = 1'b0;
      case (phase_now)
         2'b01:   wb_empty = (RW_W_Chunk == 0);
         2'b11:   wb_empty = (RO_W_Chunk == 0);
         default: wb_empty = 1'b0;
      endcase
   end

   always_comb begin
      chunk_last = '0;
      case (phase_reg)
         2'b00:   chunk_last = CW'(RW_R_Chunk - 1);
         2'b01:   chunk_last = CW'(RW_W_Chunk - 1);
         2'b10:   chunk_last = CW'(RO_R_Chunk - 1);
         default: chunk_last = CW'(RO_W_Chunk - 1);
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) state <= ST_Idle;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_Idle:
            if (phase_vld) begin
               if (!phase_now[0])  state_nxt = ST_Leaf;
               else if (wb_empty)  state_nxt = ST_Wait;
               else                state_nxt = ST_Issue;
            end
         ST_Leaf:
            if (LeafInValid) state_nxt = ST_Issue;
         ST_Issue:
            if (cmd_hs && chunk_ctr == chunk_last) state_nxt = ST_Wait;
         ST_Wait:
            // Phase code always changes on a legal REW step; waiting for that
            // absorbs the counter's latched-output delay.
            if (phase_vld && phase_now != phase_reg) state_nxt = ST_Idle;
         default: state_nxt = ST_Idle;
      endcase
   end

   always_comb begin
      LeafInReady   = (state == ST_Leaf);
      CmdValid      = (state == ST_Issue);
      Busy          = (state != ST_Idle);
      CmdWrite      = phase_reg[0];
      CmdAddr       = ADDR_WIDTH'(leaf_reg) * ADDR_WIDTH'(PATH_STRIDE)
                    + ADDR_WIDTH'(chunk_ctr) * ADDR_WIDTH'(BURST_BYTES);
      RW_R_Transfer = cmd_hs & (phase_reg == 2'b00);
      RW_W_Transfer = cmd_hs & (phase_reg == 2'b01);
      RO_R_Transfer = cmd_hs & (phase_reg == 2'b10);
      RO_W_Transfer = cmd_hs & (phase_reg == 2'b11);
   end

   // Writeback reuses leaf_reg from the preceding read of the same path.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         phase_reg <= '0;
         leaf_reg  <= '0;
         chunk_ctr <= '0;
      end else begin
         if (state == ST_Idle && phase_vld) phase_reg <= phase_now;
         if (state == ST_Leaf && LeafInValid) begin
            leaf_reg  <= LeafIn;
            chunk_ctr <= '0;
         end
         if (cmd_hs) chunk_ctr <= (chunk_ctr == chunk_last) ? '0 : chunk_ctr + 1'b1;
      end
   end

`ifdef REW_CMD_CHECK_EN
   logic err_evt;

   assign err_evt = (((state == ST_Leaf) || (state == ST_Issue))
                     && (!phase_vld || phase_now != phase_reg))
                  || (cmd_hs && phase_now != phase_reg);

   always_ff @(posedge Clock) begin
      if (Reset)        ProtocolErr <= 1'b0;
      else if (err_evt) ProtocolErr <= 1'b1;
   end

`ifdef SIMULATION
   always_ff @(posedge Clock) begin
      if (!Reset && err_evt && !ProtocolErr)
         $display("rew_path_cmd_gen: protocol error, state=%0d phase_now=%0d phase_reg=%0d",
                  state, phase_now, phase_reg);
   end
`endif
`endif

endmodule

// File: tb/tb_rew_path_cmd_gen.sv
// Directed bench for rew_path_cmd_gen with hand-computed expected values.
module tb_rew_path_cmd_gen;

   logic        Clock = 1'b0;
   logic        Reset, RWAccess, ROAccess, Read, Writeback;
   logic [15:0] LeafIn;
   logic        LeafInValid, LeafInReady;
   logic [31:0] CmdAddr;
   logic        CmdWrite, CmdValid, CmdReady;
   logic        RW_R_Transfer, RW_W_Transfer, RO_R_Transfer, RO_W_Transfer, Busy;
`ifdef REW_CMD_CHECK_EN
   logic        ProtocolErr;
`endif

   int vectors = 0;
   int miscompares = 0;

   rew_path_cmd_gen dut (
      .Clock(Clock), .Reset(Reset),
      .RWAccess(RWAccess), .ROAccess(ROAccess), .Read(Read), .Writeback(Writeback),
      .LeafIn(LeafIn), .LeafInValid(LeafInValid), .LeafInReady(LeafInReady),
      .CmdAddr(CmdAddr), .CmdWrite(CmdWrite), .CmdValid(CmdValid), .CmdReady(CmdReady),
      .RW_R_Transfer(RW_R_Transfer), .RW_W_Transfer(RW_W_Transfer),
      .RO_R_Transfer(RO_R_Transfer), .RO_W_Transfer(RO_W_Transfer),
      .Busy(Busy)
`ifdef REW_CMD_CHECK_EN
      , .ProtocolErr(ProtocolErr)
`endif
   );

   always #5 Clock = ~Clock;

   logic [3:0] xfers;
   assign xfers = {RW_R_Transfer, RW_W_Transfer, RO_R_Transfer, RO_W_Transfer};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change at the falling edge; checks follow 1 time unit later.
   task automatic cyc();
      @(negedge Clock);
   endtask

   // -1 = no phase, 0 = RW_R, 1 = RW_W, 2 = RO_R, 3 = RO_W
   task automatic set_phase(input int code);
      if (code < 0) begin
         RWAccess = 0; ROAccess = 0; Read = 0; Writeback = 0;
      end else begin
         RWAccess  = (code < 2);
         ROAccess  = (code >= 2);
         Writeback = code[0];
         Read      = !code[0];
      end
   endtask

   task automatic chk_cmd(input string tag, input logic [31:0] addr, input logic wr,
                          input logic [3:0] xf);
      chk({tag, ".valid"}, 32'(CmdValid), 32'd1);
      chk({tag, ".addr"},  CmdAddr, addr);
      chk({tag, ".write"}, 32'(CmdWrite), 32'(wr));
      chk({tag, ".xfer"},  32'(xfers), 32'(xf));
   endtask

   task automatic chk_quiet(input string tag, input logic busy);
      chk({tag, ".valid"}, 32'(CmdValid), 32'd0);
      chk({tag, ".busy"},  32'(Busy), 32'(busy));
      chk({tag, ".xfer"},  32'(xfers), 32'd0);
   endtask

   logic [9:0] rdy_pat;
   int         acc;

   initial begin
      Reset = 1; set_phase(-1); LeafIn = '0; LeafInValid = 0; CmdReady = 0;
      cyc(); cyc(); #1;
      chk_quiet("reset", 1'b0);
      chk("reset.leafrdy", 32'(LeafInReady), 32'd0);

      // RW_R, leaf 3: eight reads from 3*4096
      cyc(); Reset = 0; set_phase(0); LeafIn = 16'd3; LeafInValid = 1; CmdReady = 1; #1;
      chk("rwr.idle", 32'(Busy), 32'd0);
      cyc(); #1;
      chk("rwr.leafrdy", 32'(LeafInReady), 32'd1);
      chk("rwr.leaf_novalid", 32'(CmdValid), 32'd0);
      for (int i = 0; i < 8; i++) begin
         cyc(); LeafInValid = 0; #1;
         chk_cmd($sformatf("rwr%0d", i), 32'd12288 + 32'(i) * 32'd64, 1'b0, 4'b1000);
      end
      cyc(); #1;
      chk_quiet("rwr.wait", 1'b1);
      cyc(); #1;
      chk_quiet("rwr.wait_hold", 1'b1);

      // RW_W: eight writes to the same path, no leaf handshake
      cyc(); set_phase(1); #1;
      chk_quiet("rww.wait_to_idle", 1'b1);
      cyc(); #1;
      chk("rww.idle", 32'(Busy), 32'd0);
      for (int i = 0; i < 8; i++) begin
         cyc(); #1;
         chk_cmd($sformatf("rww%0d", i), 32'd12288 + 32'(i) * 32'd64, 1'b1, 4'b0100);
         chk("rww.leafrdy", 32'(LeafInReady), 32'd0);
      end
      cyc(); #1;
      chk_quiet("rww.wait", 1'b1);

      // RO_R, leaf 1: four reads from 4096
      cyc(); set_phase(2); LeafIn = 16'd1; LeafInValid = 1; #1;
      cyc(); #1;
      chk("ror.idle", 32'(Busy), 32'd0);
      cyc(); #1;
      chk("ror.leafrdy", 32'(LeafInReady), 32'd1);
      for (int i = 0; i < 4; i++) begin
         cyc(); LeafInValid = 0; #1;
         chk_cmd($sformatf("ror%0d", i), 32'd4096 + 32'(i) * 32'd64, 1'b0, 4'b0010);
      end

      // RO_W with zero chunks: straight to wait, nothing issued
      cyc(); set_phase(3); #1;
      chk_quiet("row.wait_prev", 1'b1);
      cyc(); #1;
      chk("row.idle", 32'(Busy), 32'd0);
      cyc(); #1;
      chk_quiet("row.wait", 1'b1);
      chk("row.leafrdy", 32'(LeafInReady), 32'd0);
      cyc(); #1;
      chk_quiet("row.wait_hold", 1'b1);

      // Next RO_R, leaf 5, with CmdReady stalls
      cyc(); set_phase(2); LeafIn = 16'd5; LeafInValid = 1; #1;
      cyc(); #1;
      chk("stall.idle", 32'(Busy), 32'd0);
      cyc(); #1;
      chk("stall.leafrdy", 32'(LeafInReady), 32'd1);
      rdy_pat = 10'b1001001001;
      acc = 0;
      for (int j = 0; j < 10; j++) begin
         cyc(); LeafInValid = 0; CmdReady = rdy_pat[j]; #1;
         chk_cmd($sformatf("stall%0d", j), 32'd20480 + 32'(acc) * 32'd64, 1'b0,
                 rdy_pat[j] ? 4'b0010 : 4'b0000);
         if (RO_R_Transfer) acc++;
      end
      cyc(); CmdReady = 1; #1;
      chk_quiet("stall.wait", 1'b1);
      chk("stall.pulses", 32'(acc), 32'd4);

      // Reset in the middle of an RW_R burst
      cyc(); set_phase(0); LeafIn = 16'd2; LeafInValid = 1; #1;
      cyc(); #1;
      cyc(); #1;
      chk("mid.leafrdy", 32'(LeafInReady), 32'd1);
      for (int i = 0; i < 3; i++) begin
         cyc(); LeafInValid = 0; #1;
         chk_cmd($sformatf("mid%0d", i), 32'd8192 + 32'(i) * 32'd64, 1'b0, 4'b1000);
      end
      cyc(); Reset = 1; #1;
      cyc(); #1;
      chk_quiet("mid.reset", 1'b0);
      chk("mid.reset_leafrdy", 32'(LeafInReady), 32'd0);
      cyc(); Reset = 0; LeafIn = 16'd6; LeafInValid = 1; #1;
      chk("fresh.idle", 32'(Busy), 32'd0);
      cyc(); #1;
      chk("fresh.leafrdy", 32'(LeafInReady), 32'd1);
      for (int i = 0; i < 2; i++) begin
         cyc(); LeafInValid = 0; #1;
         chk_cmd($sformatf("fresh%0d", i), 32'd24576 + 32'(i) * 32'd64, 1'b0, 4'b1000);
      end

`ifdef REW_CMD_CHECK_EN
      chk("perr.clear", 32'(ProtocolErr), 32'd0);
      cyc(); set_phase(1); #1;
      cyc(); #1;
      chk("perr.set", 32'(ProtocolErr), 32'd1);
      cyc(); cyc(); cyc(); #1;
      chk("perr.sticky", 32'(ProtocolErr), 32'd1);
      cyc(); Reset = 1; #1;
      cyc(); #1;
      chk("perr.reset", 32'(ProtocolErr), 32'd0);
      Reset = 0;
`endif

      cyc();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
